// File: rtl/mod5_rr_arbiter_if.sv
// rtl/mod5_rr_arbiter_if.sv - request/grant bundle for the five-way round-robin arbiter
//
// Signals:
//   en        arbitration enable (requester side -> arbiter)
//   req[4:0]  request lines, one per requester (requester side -> arbiter)
//   gnt[4:0]  one-hot grant, zero when nothing is granted (arbiter -> requesters)
//   gnt_id    index 0..4 of the grantee, holds last value when gnt is zero
//   gnt_valid high whenever gnt is non-zero
//   timeout   one-cycle pulse when a grant is forcibly released
interface mod5_rr_arbiter_if;
    logic       en;
    logic [4:0] req;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/mod5_rr_arbiter.sv
// rtl/mod5_rr_arbiter.sv - five-way round-robin arbiter with hold limit and inter-grant gap
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles a single grant is held (2..255)
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       mod5_rr_arbiter_if.slave: en/req in, gnt/gnt_id/gnt_valid/timeout out (all registered)
module mod5_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mod5_rr_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [4:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    // Round-robin search: rotate the request vector so that bit 0 is the
    // requester at ptr, take the lowest set bit, then map back mod 5.
    logic [2:0] ptr_eff;
    logic [9:0] req_dbl;
    logic [9:0] req_rot;
    logic [2:0] pos;
    logic [3:0] win_sum;
    logic [2:0] win;
    logic       found;

    always_comb begin
        // Out-of-range pointer values fall back to requester 0.
        ptr_eff = (ptr_q > 3'd4) ? 3'd0 : ptr_q;
        req_dbl = {bus.req, bus.req};
        req_rot = req_dbl >> ptr_eff;
        found   = 1'b0;
        pos     = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                pos   = 3'(k);
            end
        end
        win_sum = {1'b0, ptr_eff} + {1'b0, pos};
        win     = (win_sum >= 4'd5) ? 3'(win_sum - 4'd5) : win_sum[2:0];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d       = 5'b00000;
                gnt_valid_d = 1'b0;
                if (bus.en && found) begin
                    gnt_d       = 5'b00001 << win;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    ptr_d       = (win == 3'd4) ? 3'd0 : win + 3'd1;
                    hold_cnt_d  = 8'd0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // gnt is one-hot for the grantee, so this tests req[gnt_id].
                if ((bus.req & gnt_q) == 5'b00000) begin
                    gnt_d       = 5'b00000;
                    gnt_valid_d = 1'b0;
                    state_d     = GAP;
                end else if (hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    gnt_d       = 5'b00000;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                gnt_d       = 5'b00000;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                gnt_d       = 5'b00000;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 5'b00000;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_mod5_rr_arbiter.sv
// tb/tb_mod5_rr_arbiter.sv - directed self-checking bench for mod5_rr_arbiter
module tb_mod5_rr_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mod5_rr_arbiter_if arb ();

    mod5_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [4:0] req;
        logic [4:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] id,
                           input logic v, input logic to);
        chk({tag, " gnt"},       8'(arb.gnt),       8'(g));
        chk({tag, " gnt_id"},    8'(arb.gnt_id),    8'(id));
        chk({tag, " gnt_valid"}, 8'(arb.gnt_valid), 8'(v));
        chk({tag, " timeout"},   8'(arb.timeout),   8'(to));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        arb.en  = 1'b0;
        arb.req = 5'b00000;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        arb.en  = 1'b0;
        arb.req = 5'b00000;

        // basic grant and release
        vecs[0]  = '{1'b1, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0};
        // grant 3 moves ptr to 4, then wrap search picks 0 then 1
        vecs[5]  = '{1'b1, 5'b01000, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'b00000, 5'b00000, 3'd3, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'b00011, 5'b00000, 3'd3, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'b00011, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 5'b00010, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'b00010, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'b00010, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 5'b00000, 5'b00000, 3'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 5'b00000, 5'b00000, 3'd1, 1'b0, 1'b0};
        // enable gating, en drop mid-grant, other requests ignored and not latched
        vecs[14] = '{1'b0, 5'b01000, 5'b00000, 3'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 5'b01000, 5'b00000, 3'd1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 5'b01000, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 5'b01000, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 5'b11000, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 5'b10000, 5'b00000, 3'd3, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 5'b10000, 5'b00000, 3'd3, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 5'b10000, 5'b00000, 3'd3, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 5'b00000, 5'b00000, 3'd3, 1'b0, 1'b0};

        do_reset();
        chk_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            arb.en  = vecs[i].en;
            arb.req = vecs[i].req;
            step();
            chk_out($sformatf("row%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].to);
        end

        // timeout with MAX_HOLD=4; ptr is 4 here so requester 0 wins
        arb.en  = 1'b1;
        arb.req = 5'b00001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_out($sformatf("hold%0d", c), 5'b00001, 3'd0, 1'b1, 1'b0);
        end
        step();
        chk_out("to_gap", 5'b00000, 3'd0, 1'b0, 1'b1);
        // timed-out requester keeps requesting but now ranks behind requester 1
        arb.req = 5'b00011;
        step();
        chk_out("to_idle", 5'b00000, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("to_next", 5'b00010, 3'd1, 1'b1, 1'b0);
        arb.req = 5'b00001;
        step();
        chk_out("to_rel", 5'b00000, 3'd1, 1'b0, 1'b0);
        step();
        step();
        chk_out("to_regrant", 5'b00001, 3'd0, 1'b1, 1'b0);
        arb.req = 5'b00000;
        step();
        step();

        // rotation 0,1,2,3,4,0 from reset with all requesters active
        do_reset();
        arb.en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] e;
            logic [4:0] oh;
            e  = 3'(k % 5);
            oh = 5'b00001 << e;
            arb.req = 5'b11111;
            step();
            chk_out($sformatf("rot%0d grant", k), oh, e, 1'b1, 1'b0);
            step();
            chk_out($sformatf("rot%0d hold", k), oh, e, 1'b1, 1'b0);
            arb.req = 5'b11111 & ~oh;
            step();
            chk_out($sformatf("rot%0d gap", k), 5'b00000, e, 1'b0, 1'b0);
            arb.req = 5'b11111;
            step();
            chk_out($sformatf("rot%0d idle", k), 5'b00000, e, 1'b0, 1'b0);
        end

        // asynchronous reset mid-grant
        do_reset();
        arb.en  = 1'b1;
        arb.req = 5'b10000;
        step();
        chk_out("pre_rst", 5'b10000, 3'd4, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        arb.req = 5'b10001;
        step();
        chk_out("post_rst", 5'b00001, 3'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod5_rr_arbiter.md
MOD5_RR_ARBITER -- requirements
Module: mod5_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one grant is held (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port en, input, 1, arbitration enable; it gates new grants only.
REQ-005 The block SHALL have port req, input, 5, request lines; requester i asserts req[i] and holds it high for as long as it uses the resource.
REQ-006 The block SHALL have port gnt, output, 5, registered one-hot grant, or all-zero when no grant is held.
REQ-007 The block SHALL have port gnt_id, output, 3, registered index 0..4 of the current grantee; it holds its last value when gnt is zero.
REQ-008 The block SHALL have port gnt_valid, output, 1, registered; high exactly when gnt is non-zero.
REQ-009 The block SHALL have port timeout, output, 1, registered one-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement a 3-state FSM with states IDLE, GRANT and GAP.
REQ-011 The block SHALL keep a round-robin pointer ptr, 3 bits, that counts mod 5 (values 0..4).
REQ-012 In IDLE with en=1 and req non-zero, the block SHALL select the first set req bit found by searching ptr, ptr+1, ... with wrap 4->0 (mod 5).
REQ-013 On the selecting edge, the block SHALL assert gnt/gnt_id/gnt_valid for the winner, enter GRANT, set ptr to winner+1 mod 5 (4 wraps to 0), and clear hold_cnt to 0.
REQ-014 Grant latency SHALL be 1 cycle: req sampled in IDLE produces gnt in the next cycle.
REQ-015 In IDLE with en=0 or req all-zero, the block SHALL remain in IDLE with gnt=0 and ptr unchanged.
REQ-016 In GRANT, if req[gnt_id]=0, the block SHALL clear gnt and gnt_valid on the next edge and go to GAP.
REQ-017 In GRANT with req[gnt_id]=1 and hold_cnt < MAX_HOLD-1, the block SHALL increment hold_cnt and keep the grant.
REQ-018 In GRANT with req[gnt_id]=1 and hold_cnt = MAX_HOLD-1, the block SHALL clear gnt, pulse timeout for 1 cycle, and go to GAP; the grant therefore lasts exactly MAX_HOLD cycles.
REQ-019 GAP SHALL last exactly 1 cycle with gnt=0 and then return to IDLE, so consecutive grants are separated by at least 2 cycles with gnt=0.
REQ-020 Deasserting en while in GRANT or GAP SHALL NOT affect the current grant or the return to IDLE.
REQ-021 Requests from non-granted requesters during GRANT or GAP SHALL be ignored until IDLE; they are not latched.
REQ-022 A requester that timed out and keeps req high SHALL be arbitrated again like any other requester, at the lowest priority because ptr has moved past it.
REQ-023 If ptr ever holds 5..7, the block SHALL treat it as 0 for the search and reload it legally on the next grant.
REQ-024 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-025 While reset_n=0, the block SHALL asynchronously force state=IDLE, ptr=0, hold_cnt=0, gnt=5'b00000, gnt_id=3'b000, gnt_valid=0 and timeout=0.
REQ-026 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-027 After reset_n rises, the first grant SHALL be possible on the first clock edge at which IDLE sees en=1 and a non-zero req.

Verification
REQ-028 Basic grant: after reset, en=1, req=5'b00100 -> next cycle gnt=5'b00100, gnt_id=2; req drops -> gnt=0 next cycle, then 1 GAP cycle.
REQ-029 Rotation: req=5'b11111 held, each grantee drops req after 2 cycles -> grant order 0,1,2,3,4,0 with ptr wrapping 4->0.
REQ-030 Timeout: MAX_HOLD=4, req=5'b00001 held -> gnt high exactly 4 cycles, timeout pulses one cycle, regrant after the GAP+IDLE cycles.
REQ-031 Wrap search: ptr=4 (after a grant to 3), req=5'b00011 -> grant 0, then grant 1.
REQ-032 Enable gating: en=0 with req=5'b01000 -> gnt stays 0; en=1 -> gnt=5'b01000 next cycle; en dropped mid-grant -> grant persists.
REQ-033 Reset mid-grant: gnt=5'b10000, assert reset_n=0 -> gnt=0 and gnt_valid=0 immediately, ptr=0; release -> req=5'b10001 grants 0 first.
